// File: rtl/rsc_encoder_if.sv
// Byte-in / bit-pair-out stream bundle for the RSC encoder.
// slave: encoder side; master: byte source plus bit consumer.
interface rsc_encoder_if;
  logic [7:0] in;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_sys;
  logic       out_par;
  logic       out_last;

  modport slave (
    input  in,
    input  in_valid,
    output in_ready,
    output out_valid,
    output out_sys,
    output out_par,
    output out_last
  );

  modport master (
    output in,
    output in_valid,
    input  in_ready,
    input  out_valid,
    input  out_sys,
    input  out_par,
    input  out_last
  );
endinterface

// File: rtl/rsc_encoder.sv
// RSC constituent encoder, g0=1+D^2+D^3 (fb), g1=1+D+D^3 (ff).
// Ports: clk, reset (sync, active-low), bus (rsc_encoder_if.slave):
//   in/in_valid/in_ready byte input; out_valid/out_sys/out_par/out_last.
// Bytes are serialised LSB first, one sys/par pair per clock.
// Optional macro RSC_TAIL_EN: 3 trellis-termination bits per frame.
module rsc_encoder #(
  parameter int FRAME_BYTES = 4
) (
  input logic         clk,
  input logic         reset,
  rsc_encoder_if.slave bus
);

  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WAIT,
    TAIL
  } state_t;

  state_t state;
  state_t nxt;

  logic [2:0]    s;
  logic [7:0]    data;
  logic [BW-1:0] byte_cnt;
  logic [2:0]    bit_cnt;

  logic rdy;
  logic accept;
  logic bit_end;
  logic last_byte;
  logic enc_step;
  logic last_bit;
  logic u;
  logic a;
  logic z;

  logic ov;
  logic osys;
  logic opar;
  logic olast;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (accept) nxt = ENC;
      ENC: begin
        if (bit_end) begin
          if (last_byte) begin
`ifdef RSC_TAIL_EN
            nxt = TAIL;
`else
            nxt = IDLE;
`endif
          end else if (!accept) begin
            nxt = WAIT;
          end
        end
      end
      WAIT: if (accept) nxt = ENC;
      TAIL: if (bit_cnt == 3'd2) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bit_end   = (bit_cnt == 3'd7);
    last_byte = (byte_cnt == LAST);
    rdy       = 1'b0;
    unique case (1'b1)
      state == IDLE: rdy = 1'b1;
      state == WAIT: rdy = 1'b1;
      state == ENC:  rdy = bit_end && !last_byte;
      default:       rdy = 1'b0;
    endcase
    accept   = bus.in_valid && rdy;
    enc_step = (state == ENC) || (state == TAIL);
    // tail input cancels the feedback so a=0 and the state drains
    u = (state == TAIL) ? (s[1] ^ s[2]) : data[bit_cnt];
    a = u ^ s[1] ^ s[2];
    z = a ^ s[0] ^ s[2];
`ifdef RSC_TAIL_EN
    last_bit = (state == TAIL) && (bit_cnt == 3'd2);
`else
    last_bit = (state == ENC) && bit_end && last_byte;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s        <= '0;
      data     <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      ov       <= 1'b0;
      osys     <= 1'b0;
      opar     <= 1'b0;
      olast    <= 1'b0;
    end else begin
      ov    <= enc_step;
      osys  <= enc_step & u;
      opar  <= enc_step & z;
      olast <= last_bit;
      if (enc_step) begin
        s       <= {s[1:0], a};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if ((state == ENC) && bit_end && last_byte)
        byte_cnt <= '0;
      if (accept) begin
        data    <= bus.in;
        bit_cnt <= '0;
        if (state == IDLE) begin
          s        <= '0;
          byte_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = ov;
  assign bus.out_sys   = osys;
  assign bus.out_par   = opar;
  assign bus.out_last  = olast;

endmodule

// File: tb/tb_rsc_encoder.sv
// Scoreboard bench for rsc_encoder: polynomial-form reference
// model fills an expectation queue, a negedge monitor drains it.
module tb_rsc_encoder;

  localparam int FB = 3;
`ifdef RSC_TAIL_EN
  localparam int TAILN = 3;
`else
  localparam int TAILN = 0;
`endif
  localparam int FLEN = 8 * FB + TAILN;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rsc_encoder_if bus();

  rsc_encoder #(.FRAME_BYTES(FB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vecs = 0;
  int errs = 0;
  logic [2:0] expq[$];
  int lenq[$];
  logic parcap[$];
  int run = 0;

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Feedback sequence w: a[t] = u[t] ^ a[t-2] ^ a[t-3];
  // parity z[t] = a[t] ^ a[t-1] ^ a[t-3].
  function automatic void model(input logic [7:0] b[FB]);
    int w[$];
    w = '{0, 0, 0};
    for (int t = 0; t < FLEN; t++) begin
      int m;
      int uu;
      int aa;
      int zz;
      m = w.size();
      if (t < 8 * FB) uu = (int'(b[t / 8]) >> (t % 8)) & 1;
      else            uu = w[m-2] ^ w[m-3];
      aa = uu ^ w[m-2] ^ w[m-3];
      zz = aa ^ w[m-1] ^ w[m-3];
      w.push_back(aa);
      expq.push_back({uu[0], zz[0], (t == FLEN - 1)});
    end
  endfunction

  always @(negedge clk) begin
    logic [2:0] e;
    int l;
    if (bus.out_valid) begin
      run++;
      parcap.push_back(bus.out_par);
      vecs++;
      if (expq.size() == 0) begin
        errs++;
        $display("FAIL unexpected_out: got out_valid=1, want no output");
      end else begin
        e = expq.pop_front();
        if ({bus.out_sys, bus.out_par, bus.out_last} !== e) begin
          errs++;
          $display("FAIL out_bits: got sys/par/last=%b%b%b, want %b",
                   bus.out_sys, bus.out_par, bus.out_last, e);
        end
        if (e[0] && lenq.size() > 0) begin
          l = lenq.pop_front();
          if (l > 0) chk("gapless_run", run, l);
        end
      end
    end else begin
      run = 0;
    end
  end

  task automatic put(input logic [7:0] b, output int n);
    bit done;
    n = 0;
    done = 0;
    bus.in = b;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      n++;
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else if (n > 100) begin
        vecs++;
        errs++;
        $display("FAIL put_timeout: got no in_ready, want accept");
        done = 1;
      end
    end
  endtask

  task automatic frame(input logic [7:0] b[FB], input int gap);
    int n;
    model(b);
    lenq.push_back(gap == 0 ? FLEN : 0);
    for (int i = 0; i < FB; i++) begin
      put(b[i], n);
      if (i > 0 && gap == 0) chk("ready_spacing", n, 8);
      if (i > 0 && gap > 0)  chk("wait_ready", n, 1);
      if (gap > 0 && i < FB - 1) begin
        bus.in_valid = 1'b0;
        repeat (7 + gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.in_valid = 1'b0;
    while (expq.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    chk("drain", expq.size(), 0);
  endtask

  task automatic check_par01();
    logic [7:0] v;
    v = '0;
    if (parcap.size() < 8) begin
      chk("par01_count", parcap.size(), 8);
    end else begin
      for (int k = 0; k < 8; k++) v[k] = parcap[k];
      chk("par01_bits", int'(v), 8'h4F);
    end
  endtask

  initial begin
    logic [7:0] fb[FB];
    int n;
    bus.in = '0;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sys", bus.out_sys, 0);
    chk("rst_out_par", bus.out_par, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    parcap.delete();
    fb = '{8'h01, 8'hA5, 8'h3C};
    frame(fb, 0);
    drain();
    check_par01();

    fb = '{8'h00, 8'h00, 8'h00};
    frame(fb, 0);
    drain();

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
      frame(fb, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
    end
    drain();

    for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
    frame(fb, 5);
    drain();

    for (int i = 0; i < FB; i++) fb[i] = 8'($urandom);
    model(fb);
    lenq.push_back(0);
    put(fb[0], n);
    put(fb[1], n);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    expq.delete();
    lenq.delete();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    parcap.delete();
    fb = '{8'h01, 8'h5A, 8'hC3};
    frame(fb, 0);
    drain();
    check_par01();

    chk("queue_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
